// File: rtl/int_alu_pkg.sv
// Shared types for the execute-stage integer ALU.
// Contents: opcode enum (shared with the decoder), multiplier FSM state enum,
// and the packed flag bundle that travels with every result.
package int_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_MUL  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/int_alu_comb.sv
// Combinational result/flag generation for every single-cycle opcode.
// Ports:
//   op1, op2  : operands (op2 low SHAMT_W bits double as shift amount)
//   alu_op    : opcode
//   result_c  : combinational result (0 for MUL and undefined opcodes)
//   flags_c   : zero/neg/carry/ovf describing result_c
module int_alu_comb
  import int_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] result_c,
  output flags_t           flags_c
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHAMT_W-1:0]   shamt;

  // Extra top bit of sum is carry-out; of diff is borrow (op1 < op2 unsigned).
  always_comb begin
    sum      = {1'b0, op1} + {1'b0, op2};
    diff     = {1'b0, op1} - {1'b0, op2};
    shamt    = op2[SHAMT_W-1:0];
    result_c = '0;
    flags_c  = '0;

    case (alu_op)
      ALU_ADD:  result_c = sum[WIDTH-1:0];
      ALU_SUB:  result_c = diff[WIDTH-1:0];
      ALU_AND:  result_c = op1 & op2;
      ALU_OR:   result_c = op1 | op2;
      ALU_XOR:  result_c = op1 ^ op2;
      ALU_SLL:  result_c = op1 << shamt;
      ALU_SRL:  result_c = op1 >> shamt;
      ALU_SRA:  result_c = WIDTH'($signed(op1) >>> shamt);
      ALU_SLT:  result_c = WIDTH'($signed(op1) < $signed(op2));
      ALU_SLTU: result_c = WIDTH'(op1 < op2);
      default:  result_c = '0;  // MUL is produced by the top; 11..15 yield 0
    endcase

    flags_c.zero = (result_c == '0);
    flags_c.neg  = result_c[MSB];

    if (alu_op == ALU_ADD) begin
      flags_c.carry = sum[WIDTH];
      flags_c.ovf   = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
    end else if (alu_op == ALU_SUB) begin
      flags_c.carry = diff[WIDTH];
      flags_c.ovf   = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
    end
  end

endmodule

// File: rtl/int_alu_pipe.sv
// Handshaked integer ALU: single-cycle ops via int_alu_comb, MUL via an
// iterative shift-add FSM (one multiplier bit per cycle), registered output.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_ready  : request handshake (in_ready is combinational)
//   op1, op2, alu_op    : operands and opcode, sampled only on accept
//   out_valid, out_ready: result handshake
//   result, zero, neg, carry, ovf : registered result and its flags
//   busy                : multiply in progress
module int_alu_pipe
  import int_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [OP_W-1:0]  alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned MUL_ITER = WIDTH;
  localparam int unsigned CNT_W    = $clog2(MUL_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] mul_cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  flags_t           flags_q;

  logic             accept_c;
  logic             accept_mul_c;
  logic             load_alu_c;
  logic             mul_done_c;
  logic [WIDTH-1:0] alu_result_c;
  flags_t           alu_flags_c;
  logic [WIDTH-1:0] partial_c;
  logic [WIDTH-1:0] acc_next_c;
  flags_t           mul_flags_c;

  int_alu_comb #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_comb (
    .op1      (op1),
    .op2      (op2),
    .alu_op   (alu_op),
    .result_c (alu_result_c),
    .flags_c  (alu_flags_c)
  );

  // Accept only when idle and the output register is empty or draining now.
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);

  // Next-state and control strobes.
  always_comb begin
    state_next   = state;
    accept_c     = in_valid && in_ready;
    accept_mul_c = 1'b0;
    load_alu_c   = 1'b0;
    mul_done_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (alu_op == ALU_MUL) begin
            accept_mul_c = 1'b1;
            state_next   = ST_MUL;
          end else begin
            load_alu_c = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_cnt == CNT_LAST) begin
          mul_done_c = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One shift-add step; on the last step this is the final product.
  always_comb begin
    partial_c         = mplier[mul_cnt] ? (mcand << mul_cnt) : '0;
    acc_next_c        = acc + partial_c;
    mul_flags_c       = '0;
    mul_flags_c.zero  = (acc_next_c == '0);
    mul_flags_c.neg   = acc_next_c[WIDTH-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_cnt <= '0;
      busy    <= 1'b0;
    end else if (accept_mul_c) begin
      mcand   <= op1;
      mplier  <= op2;
      acc     <= '0;
      mul_cnt <= '0;
      busy    <= 1'b1;
    end else if (state == ST_MUL) begin
      acc     <= acc_next_c;
      mul_cnt <= mul_done_c ? '0 : mul_cnt + CNT_W'(1);
      if (mul_done_c) busy <= 1'b0;
    end
  end

  // Output register; a new load wins over a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else if (load_alu_c) begin
      result    <= alu_result_c;
      flags_q   <= alu_flags_c;
      out_valid <= 1'b1;
    end else if (mul_done_c) begin
      result    <= acc_next_c;
      flags_q   <= mul_flags_c;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero  = flags_q.zero;
  assign neg   = flags_q.neg;
  assign carry = flags_q.carry;
  assign ovf   = flags_q.ovf;

endmodule
